// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: val/rdy request controller sequencing a single-port SRAM, with a 2-entry response queue.
// Define SRAM_CTRL_RMW_EN to add the req_wmask port and read-modify-write byte-masked writes.
module sram_req_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_type,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
`ifdef SRAM_CTRL_RMW_EN
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
`endif
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    resp_type,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic                    sram_oeb,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RDATA    = 2'd2
`ifdef SRAM_CTRL_RMW_EN
    ,
    MERGE_WR = 2'd3
`endif
  } state_t;

  state_t                  state;
  logic                    cap_type;
  logic [1:0]              count;
  logic                    tail_type;
  logic [DATA_WIDTH-1:0]   tail_data;
  logic                    req_fire;
  logic                    deq;
  logic                    enq;
  logic [DATA_WIDTH-1:0]   enq_data;
  logic                    fire_rmw;
  logic                    is_rmw;

`ifdef SRAM_CTRL_RMW_EN
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [MASK_WIDTH-1:0]   cap_mask;
  logic                    cap_rmw;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [MASK_WIDTH-1:0] mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MASK_WIDTH; b++) begin
      if (mask[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

  // Any partial mask must read the old word first; all-ones is a plain write.
  assign fire_rmw = req_type && (req_wmask != {MASK_WIDTH{1'b1}});
  assign is_rmw   = cap_rmw;
`else
  assign fire_rmw = 1'b0;
  assign is_rmw   = 1'b0;
`endif

  // Only one request is ever in flight, so count < 2 guarantees it a queue slot.
  assign req_rdy  = (state == IDLE) && (count < 2'd2) && !reset;
  assign req_fire = req_val && req_rdy;
  assign deq      = resp_val && resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cap_type   <= 1'b0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_oeb   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
`ifdef SRAM_CTRL_RMW_EN
      cap_data   <= '0;
      cap_mask   <= '0;
      cap_rmw    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            cap_type  <= req_type;
            sram_addr <= req_addr;
            sram_csb  <= 1'b0;
            state     <= ACCESS;
`ifdef SRAM_CTRL_RMW_EN
            cap_data  <= req_data;
            cap_mask  <= req_wmask;
            cap_rmw   <= fire_rmw;
`endif
            if (req_type && !fire_rmw) begin
              sram_web   <= 1'b0;
              sram_oeb   <= 1'b1;
              sram_wdata <= req_data;
            end else begin
              sram_web <= 1'b1;
              sram_oeb <= 1'b0;
            end
          end
        end
        ACCESS: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          if (cap_type && !is_rmw) begin
            sram_oeb <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= RDATA;
          end
        end
        RDATA: begin
`ifdef SRAM_CTRL_RMW_EN
          if (is_rmw) begin
            sram_csb   <= 1'b0;
            sram_web   <= 1'b0;
            sram_oeb   <= 1'b1;
            sram_wdata <= merge_bytes(cap_data, sram_rdata, cap_mask);
            state      <= MERGE_WR;
          end else
`endif
          begin
            sram_oeb <= 1'b1;
            state    <= IDLE;
          end
        end
`ifdef SRAM_CTRL_RMW_EN
        MERGE_WR: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          state    <= IDLE;
        end
`endif
        default: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          sram_oeb <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Writes respond from ACCESS (or MERGE_WR), reads once RDATA has sampled the word.
  always_comb begin
    enq      = 1'b0;
    enq_data = '0;
    case (state)
      ACCESS: enq = cap_type && !is_rmw;
      RDATA: begin
        enq      = !cap_type;
        enq_data = sram_rdata;
      end
`ifdef SRAM_CTRL_RMW_EN
      MERGE_WR: enq = 1'b1;
`endif
      default: enq = 1'b0;
    endcase
  end

  // Response queue: head lives directly in the resp_* registers, tail is the second slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      resp_val  <= 1'b0;
      resp_type <= 1'b0;
      resp_data <= '0;
      tail_type <= 1'b0;
      tail_data <= '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) begin
            resp_val  <= 1'b1;
            resp_type <= cap_type;
            resp_data <= enq_data;
            count     <= 2'd1;
          end else begin
            tail_type <= cap_type;
            tail_data <= enq_data;
            count     <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            resp_type <= tail_type;
            resp_data <= tail_data;
            count     <= 2'd1;
          end else begin
            resp_val <= 1'b0;
            count    <= 2'd0;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            resp_type <= tail_type;
            resp_data <= tail_data;
            tail_type <= cap_type;
            tail_data <= enq_data;
          end else begin
            resp_type <= cap_type;
            resp_data <= enq_data;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard testbench for sram_req_ctrl with a behavioural SRAM on the pins.
// Define SRAM_CTRL_RMW_EN to also exercise masked read-modify-write writes.
module tb_sram_req_ctrl;

  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic          req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
`ifdef SRAM_CTRL_RMW_EN
  logic [7:0]    req_wmask;
`endif
  logic          resp_val;
  logic          resp_rdy;
  logic          resp_type;
  logic [DW-1:0] resp_data;
  logic          sram_csb;
  logic          sram_web;
  logic          sram_oeb;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  typedef struct {
    logic          rtype;
    logic [DW-1:0] data;
    int            fire_cycle;
    int            latency;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] sram_array [64];
  logic [DW-1:0] rdata_q;
  int            n_compared = 0;
  int            n_mismatched = 0;
  int            cyc = 0;
  int            csb_run = 0;
  logic          prev_val = 1'b0;

  sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_data   (req_data),
`ifdef SRAM_CTRL_RMW_EN
    .req_wmask  (req_wmask),
`endif
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_type  (resp_type),
    .resp_data  (resp_data),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_oeb   (sram_oeb),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: read data appears the cycle after the access, driven only while oeb is low.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) sram_array[sram_addr] <= sram_wdata;
      else rdata_q <= sram_array[sram_addr];
    end
  end
  assign sram_rdata = sram_oeb ? '0 : rdata_q;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Response monitor: chip-select pulse width, first-response latency, and in-order data.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      csb_run  = 0;
      prev_val = 1'b0;
    end else begin
      if (!sram_csb) csb_run++;
      else if (csb_run != 0) begin
        checkOutput("csb_pulse_width", csb_run, 1);
        csb_run = 0;
      end
      if (resp_val && !prev_val && sb.size() != 0)
        checkOutput("resp_latency", cyc - sb[0].fire_cycle, sb[0].latency);
      if (resp_val && resp_rdy) begin
        if (sb.size() == 0) checkOutput("unexpected_resp", 1, 0);
        else begin
          e = sb.pop_front();
          checkOutput("resp_type", resp_type, e.rtype);
          checkOutput("resp_data", resp_data, e.data);
        end
      end
      prev_val = resp_val;
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("rst_resp_val", resp_val, 0);
    checkOutput("rst_resp_type", resp_type, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_csb", sram_csb, 1);
    checkOutput("rst_web", sram_web, 1);
    checkOutput("rst_oeb", sram_oeb, 1);
    checkOutput("rst_addr", sram_addr, 0);
    checkOutput("rst_wdata", sram_wdata, 0);
  endtask

  // Drives one request, waits (bounded) for it to fire, and pushes the expected response.
  task automatic applyStimulus(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] m);
    exp_t e;
    int   waited;
    req_val  = 1'b1;
    req_type = t;
    req_addr = a;
    req_data = d;
`ifdef SRAM_CTRL_RMW_EN
    req_wmask = m;
`endif
    waited = 0;
    @(negedge clk);
    while (!req_rdy && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      checkOutput("req_fire_timeout", 0, 1);
      req_val = 1'b0;
      return;
    end
    e.fire_cycle = cyc;
    e.rtype      = t;
    if (t) begin
      e.data    = '0;
      e.latency = (m == 8'hFF) ? 2 : 4;
      for (int b = 0; b < 8; b++)
        if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      e.data    = ref_mem[a];
      e.latency = 3;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic drainScoreboard(input string tag);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b1;
    req_val  = 1'b0;
    req_type = 1'b0;
    req_addr = '0;
    req_data = '0;
`ifdef SRAM_CTRL_RMW_EN
    req_wmask = 8'hFF;
`endif
    resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_reset", req_rdy, 1);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 6'd5, 64'hDEADBEEF_01234567, 8'hFF);
    applyStimulus(1'b0, 6'd5, '0, 8'hFF);
    drainScoreboard("drain_basic");

    applyStimulus(1'b1, 6'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    applyStimulus(1'b1, 6'd63, 64'hFEDC_BA98_7654_3210, 8'hFF);
    applyStimulus(1'b0, 6'd0, '0, 8'hFF);
    applyStimulus(1'b0, 6'd63, '0, 8'hFF);
    drainScoreboard("drain_boundary");

    for (int i = 1; i < 8; i++)
      applyStimulus(1'b1, AW'(i), {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom, $urandom}, 8'hFF);
    drainScoreboard("drain_random");

    resp_rdy = 1'b0;
    applyStimulus(1'b0, 6'd5, '0, 8'hFF);
    applyStimulus(1'b0, 6'd0, '0, 8'hFF);
    req_val  = 1'b1;
    req_type = 1'b0;
    req_addr = 6'd63;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_req_rdy_low", req_rdy, 0);
    end
    checkOutput("bp_resp_val_held", resp_val, 1);
    @(posedge clk);
    #1 resp_rdy = 1'b1;
    applyStimulus(1'b0, 6'd63, '0, 8'hFF);
    drainScoreboard("drain_backpressure");

    applyStimulus(1'b0, 6'd7, '0, 8'hFF);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_mid_reset", req_rdy, 1);
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_resp_after_reset", resp_val, 0);
      checkOutput("csb_idle_after_reset", sram_csb, 1);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 6'd7, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    applyStimulus(1'b0, 6'd7, '0, 8'hFF);
    drainScoreboard("drain_recovery");

`ifdef SRAM_CTRL_RMW_EN
    applyStimulus(1'b1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus(1'b1, 6'd9, 64'h0, 8'h0F);
    applyStimulus(1'b0, 6'd9, '0, 8'hFF);
    drainScoreboard("drain_rmw");
    checkOutput("rmw_ref_word", ref_mem[9], 64'hFFFF_FFFF_0000_0000);
    applyStimulus(1'b1, 6'd9, 64'h1234_5678_9ABC_DEF0, 8'h00);
    applyStimulus(1'b1, 6'd10, 64'h1111_2222_3333_4444, 8'hFF);
    applyStimulus(1'b1, 6'd10, 64'hAAAA_BBBB_CCCC_DDDD, 8'h5A);
    applyStimulus(1'b0, 6'd9, '0, 8'hFF);
    applyStimulus(1'b0, 6'd10, '0, 8'hFF);
    drainScoreboard("drain_rmw2");
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_resp_val", resp_val, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
